mem_io_bridge: RTL and testbench
================================

# mem_io_bridge

Memory and I/O subsystem on the processor's external bus, directly downstream of the CPU's `ram_addr`/`ram_data`/`ram_we` outputs and driving its `ram_out` input. It decodes each CPU access to:
- an internal byte-wide RAM;
- a memory-mapped I/O page holding an 8-deep TX FIFO with a valid/ready output, a latched input port, and status/clear registers.

A loader port writes program bytes into RAM while `load_mode` is high.

## Interface
Parameters:
- ADDR_W, 10, RAM address width; RAM depth is 2^ADDR_W bytes.
- FIFO_DEPTH, 8, TX FIFO entries; must be a power of two, ≤ 8.
- MMIO_BASE, 16'hFF00, base address of the 4-byte I/O page.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset. **Synchronous and active-high.**
- cpu_addr  in  16  CPU bus address (`ram_addr`).
- cpu_wdata  in  8  CPU write data (`ram_data`).
- cpu_we  in  1  CPU write enable (`ram_we`).
- cpu_rdata  out  8  read data to CPU (`ram_out`).
- load_mode  in  1  loader owns RAM writes.
- load_valid  in  1  loader byte valid.
- load_ready  out  1  loader byte accepted.
- load_addr  in  ADDR_W  loader RAM address.
- load_data  in  8  loader byte.
- tx_data  out  8  FIFO head byte.
- tx_valid  out  1  FIFO non-empty.
- tx_ready  in  1  consumer accepts head.
- in_port  in  8  external input byte.
- in_strobe  in  1  capture `in_port` this cycle.

## Operation
Address decode:
- `cpu_addr < 2^ADDR_W`: RAM.
- `MMIO_BASE..MMIO_BASE+3`: I/O registers.
- Any other address: reads return 8'h00; writes are ignored.

RAM:
- Asynchronous read at `cpu_addr[ADDR_W-1:0]`.
- Written on the clk edge when `cpu_we` is high and `load_mode` is low.
- Contents are not cleared by `rst`.

I/O registers (offset from MMIO_BASE):
- +0 TX_DATA
  - Write pushes `cpu_wdata` into the FIFO.
  - If the FIFO is full and no pop occurs this cycle, the byte is dropped and `tx_ovf` is set.
  - Reads return 8'h00.
- +1 STATUS
  - Read: {tx_ovf, in_ovr, in_valid, full, count[3:0]}.
  - Write: bit7=1 clears `tx_ovf`; bit6=1 clears `in_ovr`.
- +2 IN_DATA
  - Read returns the latched input byte. Reading has no side effects.
  - Any write clears `in_valid`.
- +3 reserved: reads 8'h00, writes ignored.

Input port:
- `in_strobe` latches `in_port` and sets `in_valid`.
- If `in_valid` was already 1, the byte is overwritten and `in_ovr` is set.
- If `in_strobe` and a write to +2 occur in the same cycle, the strobe wins: new byte latched, `in_valid`=1.
- A clear write to STATUS and a set event in the same cycle: the set wins.

TX FIFO:
- `tx_valid` = (count≠0); `tx_data` = head entry.
- Pop when `tx_valid && tx_ready`.
- Push is accepted when count<FIFO_DEPTH, or when a pop occurs in the same cycle; in the full case with a pop, count stays FIFO_DEPTH.
- Pointers wrap modulo FIFO_DEPTH.

Loader:
- `load_ready` = `load_mode`.
- When `load_mode && load_valid`, `load_data` is written to `load_addr`.
- While `load_mode`=1, all CPU writes (RAM and MMIO) are suppressed. CPU reads continue to be served.

## Timing
- `cpu_rdata` is combinational from `cpu_addr` and current state, with zero-cycle latency. RAM writes are visible on the cycle after the write edge.
- A push on edge N gives `tx_valid`=1 after edge N. A pop removes the head at the edge.
- `in_strobe` at edge N shows in STATUS and IN_DATA after edge N.
- Reset values (`rst` sampled high at an edge):
  - count=0, `tx_valid`=0, `tx_data`=8'h00 (empty storage reads 0).
  - `tx_ovf`=0, `in_ovr`=0, `in_valid`=0, IN_DATA=8'h00.
  - `load_ready` follows `load_mode`.
- Reset mid-operation flushes the FIFO and discards any push or pop in that cycle. Loader writes in a reset cycle are still performed, since RAM is not reset.

## Test plan
- Loader writes 0x3E→0x000, 0x05→0x001 with `load_mode`=1 → after `load_mode`=0, CPU reads at 0x0000/0x0001 return 0x3E/0x05. A CPU write to 0x0000 during `load_mode`=1 → RAM still holds 0x3E.
- CPU writes 0x41,0x42 to 0xFF00 with `tx_ready`=0 → STATUS=0x02; `tx_data`=0x41. Raise `tx_ready` → outputs 0x41 then 0x42; STATUS returns to 0x00.
- Nine pushes to 0xFF00 with `tx_ready`=0 → STATUS=0x98 (`tx_ovf`, full, count 8). Write 0x80 to 0xFF01 → STATUS=0x18.
- Push with full FIFO and `tx_ready`=1 in the same cycle → count stays 8, no `tx_ovf`; the pushed byte emerges last.
- `in_strobe` with `in_port`=0x7A → IN_DATA=0x7A, STATUS bit5=1. A second strobe with 0x11 → IN_DATA=0x11, bit6 set. Write to 0xFF02 with a simultaneous strobe → `in_valid` remains 1.
- Assert `rst` with 3 bytes queued and `tx_ovf` set → next cycle STATUS=0x00, `tx_valid`=0; RAM byte at 0x0000 unchanged.

Source files
------------

// File: rtl/mem_io_bridge.sv
`default_nettype none
// ============================================================================
// Module : mem_io_bridge
// Brief  : CPU-bus RAM plus an MMIO page with TX FIFO, input latch and status.
// Rev    : 1.0  initial release
// ============================================================================
module mem_io_bridge #(
  parameter int          ADDR_W     = 10,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [15:0] MMIO_BASE  = 16'hFF00
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       cpu_addr,
  input  logic [7:0]        cpu_wdata,
  input  logic              cpu_we,
  output logic [7:0]        cpu_rdata,
  input  logic              load_mode,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [7:0]        load_data,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  input  logic [7:0]        in_port,
  input  logic              in_strobe
);

  localparam int               PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [3:0]       c_depth = 4'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] c_last  = PTR_W'(FIFO_DEPTH - 1);

  logic [7:0]       r_ram  [2**ADDR_W];
  logic [7:0]       r_fifo [FIFO_DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [3:0]       r_count;
  logic             r_tx_ovf;
  logic             r_in_ovr;
  logic             r_in_valid;
  logic [7:0]       r_in_data;

  logic [15:0]      w_off;
  logic             w_sel_ram;
  logic             w_sel_mmio;
  logic             w_cpu_wr;
  logic             w_wr_tx;
  logic             w_wr_stat;
  logic             w_wr_in;
  logic             w_full;
  logic             w_pop;
  logic             w_push;
  logic [7:0]       w_status;

  function automatic logic [PTR_W-1:0] f_ptr_inc(input logic [PTR_W-1:0] p);
    return (p == c_last) ? '0 : p + PTR_W'(1);
  endfunction

  // RAM decode takes priority so a low MMIO_BASE can never shadow RAM.
  assign w_off      = cpu_addr - MMIO_BASE;
  assign w_sel_ram  = (cpu_addr >> ADDR_W) == 16'd0;
  assign w_sel_mmio = !w_sel_ram && (w_off < 16'd4);
  assign w_cpu_wr   = cpu_we && !load_mode;
  assign w_wr_tx    = w_cpu_wr && w_sel_mmio && (w_off[1:0] == 2'd0);
  assign w_wr_stat  = w_cpu_wr && w_sel_mmio && (w_off[1:0] == 2'd1);
  assign w_wr_in    = w_cpu_wr && w_sel_mmio && (w_off[1:0] == 2'd2);

  assign w_full     = (r_count == c_depth);
  assign tx_valid   = (r_count != 4'd0);
  assign tx_data    = r_fifo[r_rd_ptr];
  assign w_pop      = tx_valid && tx_ready;
  assign w_push     = w_wr_tx && (!w_full || w_pop);
  assign load_ready = load_mode;
  assign w_status   = {r_tx_ovf, r_in_ovr, r_in_valid, w_full, r_count};

  // RAM has no reset; loader writes still land during a reset cycle.
  always_ff @(posedge clk) begin
    if (load_mode) begin
      if (load_valid) begin
        r_ram[load_addr] <= load_data;
      end
    end else if (cpu_we && w_sel_ram) begin
      r_ram[cpu_addr[ADDR_W-1:0]] <= cpu_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= 4'd0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_fifo[i] <= 8'h00;
      end
    end else begin
      // When full with a pop, wr_ptr equals rd_ptr: the head slot is reused.
      if (w_push) begin
        r_fifo[r_wr_ptr] <= cpu_wdata;
        r_wr_ptr         <= f_ptr_inc(r_wr_ptr);
      end
      if (w_pop) begin
        r_rd_ptr <= f_ptr_inc(r_rd_ptr);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 4'd1;
        2'b01:   r_count <= r_count - 4'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Clears are assigned before sets so a same-cycle set event wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx_ovf   <= 1'b0;
      r_in_ovr   <= 1'b0;
      r_in_valid <= 1'b0;
      r_in_data  <= 8'h00;
    end else begin
      if (w_wr_stat && cpu_wdata[7]) begin
        r_tx_ovf <= 1'b0;
      end
      if (w_wr_tx && w_full && !w_pop) begin
        r_tx_ovf <= 1'b1;
      end
      if (w_wr_stat && cpu_wdata[6]) begin
        r_in_ovr <= 1'b0;
      end
      if (w_wr_in) begin
        r_in_valid <= 1'b0;
      end
      if (in_strobe) begin
        r_in_data  <= in_port;
        r_in_valid <= 1'b1;
        if (r_in_valid) begin
          r_in_ovr <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    cpu_rdata = 8'h00;
    if (w_sel_ram) begin
      cpu_rdata = r_ram[cpu_addr[ADDR_W-1:0]];
    end else if (w_sel_mmio) begin
      case (w_off[1:0])
        2'd1:    cpu_rdata = w_status;
        2'd2:    cpu_rdata = r_in_data;
        default: cpu_rdata = 8'h00;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_io_bridge.sv
`default_nettype none
// ============================================================================
// Module : tb_mem_io_bridge
// Brief  : Directed scenarios plus randomized traffic against a queue model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_mem_io_bridge;

  localparam int          ADDR_W = 10;
  localparam int          DEPTH  = 8;
  localparam logic [15:0] BASE   = 16'hFF00;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [15:0]       cpu_addr = 16'h0;
  logic [7:0]        cpu_wdata = 8'h0;
  logic              cpu_we = 1'b0;
  logic [7:0]        cpu_rdata;
  logic              load_mode = 1'b0;
  logic              load_valid = 1'b0;
  logic              load_ready;
  logic [ADDR_W-1:0] load_addr = '0;
  logic [7:0]        load_data = 8'h0;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready = 1'b0;
  logic [7:0]        in_port = 8'h0;
  logic              in_strobe = 1'b0;

  always #5 clk = ~clk;

  mem_io_bridge #(.ADDR_W(ADDR_W), .FIFO_DEPTH(DEPTH), .MMIO_BASE(BASE)) dut (
    .clk(clk), .rst(rst), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_we(cpu_we), .cpu_rdata(cpu_rdata), .load_mode(load_mode),
    .load_valid(load_valid), .load_ready(load_ready), .load_addr(load_addr),
    .load_data(load_data), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .in_port(in_port), .in_strobe(in_strobe)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: FIFO as a queue, flags as plain bits, RAM as an array.
  logic [7:0] m_q[$];
  logic       m_tx_ovf = 1'b0;
  logic       m_in_ovr = 1'b0;
  logic       m_in_valid = 1'b0;
  logic [7:0] m_in_data = 8'h00;
  logic [7:0] m_ram   [1024];
  bit         m_known [1024];

  function automatic logic [7:0] m_status();
    return {m_tx_ovf, m_in_ovr, m_in_valid, m_q.size() == DEPTH, 4'(m_q.size())};
  endfunction

  function automatic bit m_read(input logic [15:0] a, output logic [7:0] d);
    d = 8'h00;
    if (a < 16'd1024) begin
      d = m_ram[a[9:0]];
      return m_known[a[9:0]];
    end
    if (a == BASE + 16'd1) d = m_status();
    else if (a == BASE + 16'd2) d = m_in_data;
    return 1'b1;
  endfunction

  task automatic model_edge();
    bit wr, pop, push_req, was_valid;
    wr = cpu_we && !load_mode;
    if (load_mode && load_valid) begin
      m_ram[load_addr] = load_data;
      m_known[load_addr] = 1'b1;
    end else if (wr && cpu_addr < 16'd1024) begin
      m_ram[cpu_addr[9:0]] = cpu_wdata;
      m_known[cpu_addr[9:0]] = 1'b1;
    end
    if (rst) begin
      m_q.delete();
      m_tx_ovf = 1'b0; m_in_ovr = 1'b0; m_in_valid = 1'b0; m_in_data = 8'h00;
      return;
    end
    pop = (m_q.size() != 0) && tx_ready;
    push_req = wr && (cpu_addr == BASE);
    if (wr && cpu_addr == BASE + 16'd1) begin
      if (cpu_wdata[7]) m_tx_ovf = 1'b0;
      if (cpu_wdata[6]) m_in_ovr = 1'b0;
    end
    if (push_req && m_q.size() == DEPTH && !pop) m_tx_ovf = 1'b1;
    if (pop) void'(m_q.pop_front());
    if (push_req && m_q.size() < DEPTH) m_q.push_back(cpu_wdata);
    was_valid = m_in_valid;
    if (wr && cpu_addr == BASE + 16'd2) m_in_valid = 1'b0;
    if (in_strobe) begin
      m_in_data = in_port;
      m_in_valid = 1'b1;
      if (was_valid) m_in_ovr = 1'b1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    cpu_addr = a; cpu_wdata = d; cpu_we = 1'b1;
    tick();
    cpu_we = 1'b0;
  endtask

  task automatic rd(input logic [15:0] a);
    cpu_addr = a; cpu_we = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    n_cmp++; if (tx_valid !== 1'b0) begin n_err++; $display("FAIL reset_tx_valid: got %b want 0", tx_valid); end
    n_cmp++; if (tx_data !== 8'h00) begin n_err++; $display("FAIL reset_tx_data: got %h want 00", tx_data); end
    rd(BASE + 16'd1);
    n_cmp++; if (cpu_rdata !== 8'h00) begin n_err++; $display("FAIL reset_status: got %h want 00", cpu_rdata); end
    rd(BASE + 16'd2);
    n_cmp++; if (cpu_rdata !== 8'h00) begin n_err++; $display("FAIL reset_in_data: got %h want 00", cpu_rdata); end
    load_mode = 1'b1; #1;
    n_cmp++; if (load_ready !== 1'b1) begin n_err++; $display("FAIL load_ready_hi: got %b want 1", load_ready); end
    load_mode = 1'b0; #1;
    n_cmp++; if (load_ready !== 1'b0) begin n_err++; $display("FAIL load_ready_lo: got %b want 0", load_ready); end
  endtask

  task automatic test_loader();
    load_mode = 1'b1; load_valid = 1'b1;
    load_addr = 10'h000; load_data = 8'h3E; tick();
    load_addr = 10'h001; load_data = 8'h05; tick();
    load_valid = 1'b0;
    wr(16'h0000, 8'hAA);
    wr(BASE, 8'h99);
    n_cmp++; if (tx_valid !== 1'b0) begin n_err++; $display("FAIL load_blocks_mmio: got tx_valid %b want 0", tx_valid); end
    load_mode = 1'b0;
    rd(16'h0000);
    n_cmp++; if (cpu_rdata !== 8'h3E) begin n_err++; $display("FAIL load_byte0: got %h want 3e", cpu_rdata); end
    rd(16'h0001);
    n_cmp++; if (cpu_rdata !== 8'h05) begin n_err++; $display("FAIL load_byte1: got %h want 05", cpu_rdata); end
    wr(16'h0123, 8'h5C);
    rd(16'h0123);
    n_cmp++; if (cpu_rdata !== 8'h5C) begin n_err++; $display("FAIL cpu_ram_wr: got %h want 5c", cpu_rdata); end
    wr(16'h8000, 8'h77);
    rd(16'h8000);
    n_cmp++; if (cpu_rdata !== 8'h00) begin n_err++; $display("FAIL unmapped_rd: got %h want 00", cpu_rdata); end
    rd(BASE + 16'd3);
    n_cmp++; if (cpu_rdata !== 8'h00) begin n_err++; $display("FAIL reserved_rd: got %h want 00", cpu_rdata); end
  endtask

  task automatic test_tx_fifo();
    tx_ready = 1'b0;
    wr(BASE, 8'h41);
    wr(BASE, 8'h42);
    rd(BASE);
    n_cmp++; if (cpu_rdata !== 8'h00) begin n_err++; $display("FAIL tx_data_reg_rd: got %h want 00", cpu_rdata); end
    rd(BASE + 16'd1);
    n_cmp++; if (cpu_rdata !== 8'h02) begin n_err++; $display("FAIL tx_status2: got %h want 02", cpu_rdata); end
    n_cmp++; if (tx_data !== 8'h41 || tx_valid !== 1'b1) begin n_err++; $display("FAIL tx_head1: got %h/%b want 41/1", tx_data, tx_valid); end
    tx_ready = 1'b1;
    tick();
    n_cmp++; if (tx_data !== 8'h42 || tx_valid !== 1'b1) begin n_err++; $display("FAIL tx_head2: got %h/%b want 42/1", tx_data, tx_valid); end
    tick();
    tx_ready = 1'b0;
    n_cmp++; if (tx_valid !== 1'b0) begin n_err++; $display("FAIL tx_empty: got %b want 0", tx_valid); end
    n_cmp++; if (cpu_rdata !== 8'h00) begin n_err++; $display("FAIL tx_status0: got %h want 00", cpu_rdata); end
  endtask

  task automatic test_overflow();
    logic [7:0] exp [8];
    tx_ready = 1'b0;
    for (int i = 0; i < 9; i++) wr(BASE, 8'(8'h10 + i));
    rd(BASE + 16'd1);
    n_cmp++; if (cpu_rdata !== 8'h98) begin n_err++; $display("FAIL ovf_status: got %h want 98", cpu_rdata); end
    wr(BASE + 16'd1, 8'h80);
    n_cmp++; if (cpu_rdata !== 8'h18) begin n_err++; $display("FAIL ovf_clear: got %h want 18", cpu_rdata); end
    tx_ready = 1'b1;
    n_cmp++; if (tx_data !== 8'h10) begin n_err++; $display("FAIL full_head: got %h want 10", tx_data); end
    wr(BASE, 8'hEE);
    tx_ready = 1'b0;
    rd(BASE + 16'd1);
    n_cmp++; if (cpu_rdata !== 8'h18) begin n_err++; $display("FAIL full_push_pop: got %h want 18", cpu_rdata); end
    for (int i = 0; i < 7; i++) exp[i] = 8'(8'h11 + i);
    exp[7] = 8'hEE;
    tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      n_cmp++; if (tx_data !== exp[i] || tx_valid !== 1'b1) begin n_err++; $display("FAIL drain_%0d: got %h want %h", i, tx_data, exp[i]); end
      tick();
    end
    tx_ready = 1'b0;
    n_cmp++; if (tx_valid !== 1'b0) begin n_err++; $display("FAIL drain_empty: got %b want 0", tx_valid); end
  endtask

  task automatic test_in_port();
    in_port = 8'h7A; in_strobe = 1'b1; tick(); in_strobe = 1'b0;
    rd(BASE + 16'd2);
    n_cmp++; if (cpu_rdata !== 8'h7A) begin n_err++; $display("FAIL in_first: got %h want 7a", cpu_rdata); end
    rd(BASE + 16'd1);
    n_cmp++; if (cpu_rdata !== 8'h20) begin n_err++; $display("FAIL in_valid_status: got %h want 20", cpu_rdata); end
    in_port = 8'h11; in_strobe = 1'b1; tick(); in_strobe = 1'b0;
    n_cmp++; if (cpu_rdata !== 8'h60) begin n_err++; $display("FAIL in_ovr_status: got %h want 60", cpu_rdata); end
    rd(BASE + 16'd2);
    n_cmp++; if (cpu_rdata !== 8'h11) begin n_err++; $display("FAIL in_second: got %h want 11", cpu_rdata); end
    in_port = 8'h33; in_strobe = 1'b1; wr(BASE + 16'd2, 8'h00); in_strobe = 1'b0;
    rd(BASE + 16'd1);
    n_cmp++; if (cpu_rdata !== 8'h60) begin n_err++; $display("FAIL strobe_beats_clr: got %h want 60", cpu_rdata); end
    wr(BASE + 16'd2, 8'h00);
    rd(BASE + 16'd1);
    n_cmp++; if (cpu_rdata !== 8'h40) begin n_err++; $display("FAIL in_data_clr: got %h want 40", cpu_rdata); end
    wr(BASE + 16'd1, 8'h40);
    n_cmp++; if (cpu_rdata !== 8'h00) begin n_err++; $display("FAIL ovr_clr: got %h want 00", cpu_rdata); end
    in_strobe = 1'b1; tick();
    wr(BASE + 16'd1, 8'h40); in_strobe = 1'b0;
    n_cmp++; if (cpu_rdata !== 8'h60) begin n_err++; $display("FAIL ovr_set_beats_clr: got %h want 60", cpu_rdata); end
    wr(BASE + 16'd2, 8'h00);
    wr(BASE + 16'd1, 8'h40);
  endtask

  task automatic test_reset_mid();
    tx_ready = 1'b0;
    for (int i = 0; i < 9; i++) wr(BASE, 8'(8'hA0 + i));
    tx_ready = 1'b1;
    repeat (5) tick();
    tx_ready = 1'b0;
    rd(BASE + 16'd1);
    n_cmp++; if (cpu_rdata !== 8'h83) begin n_err++; $display("FAIL pre_reset_status: got %h want 83", cpu_rdata); end
    tx_ready = 1'b1; rst = 1'b1; tick(); rst = 1'b0; tx_ready = 1'b0;
    n_cmp++; if (cpu_rdata !== 8'h00) begin n_err++; $display("FAIL mid_reset_status: got %h want 00", cpu_rdata); end
    n_cmp++; if (tx_valid !== 1'b0 || tx_data !== 8'h00) begin n_err++; $display("FAIL mid_reset_tx: got %b/%h want 0/00", tx_valid, tx_data); end
    rd(16'h0000);
    n_cmp++; if (cpu_rdata !== 8'h3E) begin n_err++; $display("FAIL ram_survives_reset: got %h want 3e", cpu_rdata); end
  endtask

  task automatic test_random();
    logic [7:0] e;
    bit k;
    for (int c = 0; c < 600; c++) begin
      int sel;
      sel = $urandom_range(0, 9);
      case (sel)
        0, 1, 2, 3: cpu_addr = BASE + 16'(sel);
        4, 5, 6:    cpu_addr = 16'($urandom_range(0, 15));
        7:          cpu_addr = 16'($urandom_range(1024, 65279));
        default:    cpu_addr = BASE;
      endcase
      cpu_we     = ($urandom_range(0, 1) == 1);
      cpu_wdata  = 8'($urandom);
      tx_ready   = ($urandom_range(0, 2) != 0);
      in_strobe  = ($urandom_range(0, 3) == 0);
      in_port    = 8'($urandom);
      load_mode  = ($urandom_range(0, 11) == 0);
      load_valid = ($urandom_range(0, 1) == 1);
      load_addr  = 10'($urandom_range(0, 15));
      load_data  = 8'($urandom);
      rst        = ($urandom_range(0, 79) == 0);
      #1;
      k = m_read(cpu_addr, e);
      if (k) begin
        n_cmp++; if (cpu_rdata !== e) begin n_err++; $display("FAIL rnd_rdata c=%0d addr=%h: got %h want %h", c, cpu_addr, cpu_rdata, e); end
      end
      n_cmp++; if (load_ready !== load_mode) begin n_err++; $display("FAIL rnd_load_ready c=%0d: got %b want %b", c, load_ready, load_mode); end
      tick();
      n_cmp++; if (tx_valid !== (m_q.size() != 0)) begin n_err++; $display("FAIL rnd_tx_valid c=%0d: got %b want %b", c, tx_valid, m_q.size() != 0); end
      if (m_q.size() != 0) begin
        n_cmp++; if (tx_data !== m_q[0]) begin n_err++; $display("FAIL rnd_tx_data c=%0d: got %h want %h", c, tx_data, m_q[0]); end
      end
    end
    rst = 1'b0; cpu_we = 1'b0; in_strobe = 1'b0; load_mode = 1'b0; load_valid = 1'b0; tx_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_loader();
    test_tx_fifo();
    test_overflow();
    test_in_port();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
